// File: rtl/snake_pkg.sv
// snake_pkg: shared constants, encodings and reset-value helpers for the
// snake body controller and its collision sub-block.
//   - grid and body-length limits
//   - direction and FSM state encodings
//   - initial body layout (head at (24,32), body trailing to the left)
package snake_pkg;

  localparam int XSIZE     = 48;   // legal x is 0..XSIZE-1
  localparam int YSIZE     = 64;   // legal y is 0..YSIZE-1
  localparam int MAX_SIZE  = 100;  // maximum body length in segments
  localparam int INIT_SIZE = 3;    // body length after reset or start
  localparam int COORD_W   = 6;

  localparam logic [1:0] DIR_UP    = 2'b00;  // y-1
  localparam logic [1:0] DIR_DOWN  = 2'b01;  // y+1
  localparam logic [1:0] DIR_LEFT  = 2'b10;  // x-1
  localparam logic [1:0] DIR_RIGHT = 2'b11;  // x+1

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [COORD_W-1:0] INIT_HEAD_X = 6'd24;
  localparam logic [COORD_W-1:0] INIT_HEAD_Y = 6'd32;

  // Initial segment k: trails the head to the left on the head's row;
  // segments beyond the initial length are zero.
  function automatic logic [COORD_W-1:0] init_seg_x(input int k);
    return (k < INIT_SIZE) ? INIT_HEAD_X - COORD_W'(k) : '0;
  endfunction

  function automatic logic [COORD_W-1:0] init_seg_y(input int k);
    return (k < INIT_SIZE) ? INIT_HEAD_Y : '0;
  endfunction

  // The encodings pair opposite directions in bit 0 (up/down, left/right).
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_body_ctrl_if.sv
// snake_body_ctrl_if: item-position handshake between the body controller
// (master, requester) and the item generator (slave).
//   o_Item_Req  : master -> slave, level request for a new item position
//   i_Item_x/y  : slave -> master, item position
//   i_Item_Done : slave -> master, position valid while high
// Handshake: o_Item_Req acts as ready and i_Item_Done as valid. A transfer
// happens on the first rising clock edge where both are high; the master
// drops o_Item_Req on the following cycle. The slave must hold i_Item_x/y
// stable while i_Item_Done is high.
interface snake_body_ctrl_if;
  logic       o_Item_Req;
  logic [5:0] i_Item_x;
  logic [5:0] i_Item_y;
  logic       i_Item_Done;

  modport master (output o_Item_Req, input i_Item_x, input i_Item_y, input i_Item_Done);
  modport slave  (input o_Item_Req, output i_Item_x, output i_Item_y, output i_Item_Done);
endinterface

// File: rtl/snake_collide.sv
// snake_collide: combinational self-collision check.
//   head_x/head_y : candidate next head position
//   body_x/body_y : packed segments, segment k at bits [6k+5:6k]
//   size          : current body length
//   eat           : the move also eats, so the tail stays in place
//   hit           : candidate head lands on an occupied segment
module snake_collide
  import snake_pkg::*;
(
  input  logic [COORD_W-1:0]          head_x,
  input  logic [COORD_W-1:0]          head_y,
  input  logic [MAX_SIZE*COORD_W-1:0] body_x,
  input  logic [MAX_SIZE*COORD_W-1:0] body_y,
  input  logic [11:0]                 size,
  input  logic                        eat,
  output logic                        hit
);

  logic [11:0] limit;

  // Without an eat the tail moves away this same tick, so it is not an
  // obstacle; with an eat it stays and must be included.
  always_comb begin
    hit   = 1'b0;
    limit = eat ? size : size - 12'd1;
    for (int k = 0; k < MAX_SIZE; k++) begin
      if ((12'(k) < limit) &&
          (body_x[COORD_W*k +: COORD_W] == head_x) &&
          (body_y[COORD_W*k +: COORD_W] == head_y)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: owns the snake body, moves it on game ticks, detects
// eating, wall hits and self-collisions, and requests new item positions.
//   i_Clk, i_Rst     : clock, asynchronous active-low reset
//   i_Start          : start pulse (honoured in IDLE and OVER)
//   i_Move_Tick      : advance pulse (honoured in RUN)
//   i_Dir            : requested direction
//   item             : item handshake (master side)
//   o_Body_x/y       : packed segments, segment 0 is the head
//   o_Body_size      : current length, o_Score : items eaten
//   o_Eat            : one-cycle pulse per eat, o_Game_Over : OVER state
//   o_State          : current FSM state for observation
module snake_body_ctrl
  import snake_pkg::*;
(
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Start,
  input  logic                        i_Move_Tick,
  input  logic [1:0]                  i_Dir,
  snake_body_ctrl_if.master           item,
  output logic [MAX_SIZE*COORD_W-1:0] o_Body_x,
  output logic [MAX_SIZE*COORD_W-1:0] o_Body_y,
  output logic [11:0]                 o_Body_size,
  output logic [11:0]                 o_Score,
  output logic                        o_Eat,
  output logic                        o_Game_Over,
  output state_e                      o_State
);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] body_x_q [MAX_SIZE];
  logic [COORD_W-1:0] body_x_d [MAX_SIZE];
  logic [COORD_W-1:0] body_y_q [MAX_SIZE];
  logic [COORD_W-1:0] body_y_d [MAX_SIZE];
  logic [11:0]        size_q, size_d;
  logic [11:0]        score_q, score_d;
  logic [1:0]         dir_pend_q, dir_pend_d;  // direction for the next tick
  logic [1:0]         dir_app_q, dir_app_d;    // direction of the last move
  logic               eat_q, eat_d;
  logic [COORD_W-1:0] item_x_q, item_x_d;
  logic [COORD_W-1:0] item_y_q, item_y_d;
  logic               item_valid_q, item_valid_d;

  logic [6:0] next_x, next_y;
  logic       wall_hit, eat_hit, self_hit;

  for (genvar g = 0; g < MAX_SIZE; g++) begin : g_pack
    assign o_Body_x[COORD_W*g +: COORD_W] = body_x_q[g];
    assign o_Body_y[COORD_W*g +: COORD_W] = body_y_q[g];
  end

  // 7-bit next head: stepping below 0 wraps to 127, so every wall case
  // shows up as an out-of-range coordinate.
  always_comb begin
    next_x = {1'b0, body_x_q[0]};
    next_y = {1'b0, body_y_q[0]};
    case (dir_pend_q)
      DIR_UP:    next_y = next_y - 7'd1;
      DIR_DOWN:  next_y = next_y + 7'd1;
      DIR_LEFT:  next_x = next_x - 7'd1;
      default:   next_x = next_x + 7'd1;
    endcase
  end

  assign wall_hit = (next_x >= 7'(XSIZE)) || (next_y >= 7'(YSIZE));
  assign eat_hit  = item_valid_q && (next_x == {1'b0, item_x_q}) &&
                    (next_y == {1'b0, item_y_q});

  snake_collide u_collide (
    .head_x (next_x[COORD_W-1:0]),
    .head_y (next_y[COORD_W-1:0]),
    .body_x (o_Body_x),
    .body_y (o_Body_y),
    .size   (size_q),
    .eat    (eat_hit),
    .hit    (self_hit)
  );

  always_comb begin
    state_d      = state_q;
    body_x_d     = body_x_q;
    body_y_d     = body_y_q;
    size_d       = size_q;
    score_d      = score_q;
    dir_pend_d   = dir_pend_q;
    dir_app_d    = dir_app_q;
    eat_d        = 1'b0;
    item_x_d     = item_x_q;
    item_y_d     = item_y_q;
    item_valid_d = item_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (item.i_Item_Done) begin
          item_x_d     = item.i_Item_x;
          item_y_d     = item.i_Item_y;
          item_valid_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // A tick this cycle uses the previously latched pending direction.
        if (i_Dir != dir_reverse(dir_app_q)) dir_pend_d = i_Dir;
        if (i_Move_Tick) begin
          if (wall_hit || self_hit) begin
            state_d = ST_OVER;
          end else begin
            for (int k = 1; k < MAX_SIZE; k++) begin
              body_x_d[k] = body_x_q[k-1];
              body_y_d[k] = body_y_q[k-1];
            end
            body_x_d[0] = next_x[COORD_W-1:0];
            body_y_d[0] = next_y[COORD_W-1:0];
            dir_app_d   = dir_pend_q;
            if (eat_hit) begin
              // The shift already kept the old tail; growing just exposes it.
              if (size_q < 12'(MAX_SIZE)) size_d = size_q + 12'd1;
              if (score_q != 12'hfff)     score_d = score_q + 12'd1;
              eat_d        = 1'b1;
              item_valid_d = 1'b0;
              state_d      = ST_REQ;
            end
          end
        end
      end
      ST_OVER: begin
        if (i_Start) begin
          for (int k = 0; k < MAX_SIZE; k++) begin
            body_x_d[k] = init_seg_x(k);
            body_y_d[k] = init_seg_y(k);
          end
          size_d     = 12'(INIT_SIZE);
          score_d    = '0;
          dir_pend_d = DIR_RIGHT;
          dir_app_d  = DIR_RIGHT;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < MAX_SIZE; k++) begin
        body_x_q[k] <= init_seg_x(k);
        body_y_q[k] <= init_seg_y(k);
      end
      size_q       <= 12'(INIT_SIZE);
      score_q      <= '0;
      dir_pend_q   <= DIR_RIGHT;
      dir_app_q    <= DIR_RIGHT;
      eat_q        <= 1'b0;
      item_x_q     <= '0;
      item_y_q     <= '0;
      item_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      body_x_q     <= body_x_d;
      body_y_q     <= body_y_d;
      size_q       <= size_d;
      score_q      <= score_d;
      dir_pend_q   <= dir_pend_d;
      dir_app_q    <= dir_app_d;
      eat_q        <= eat_d;
      item_x_q     <= item_x_d;
      item_y_q     <= item_y_d;
      item_valid_q <= item_valid_d;
    end
  end

  assign item.o_Item_Req = (state_q == ST_REQ);
  assign o_Body_size     = size_q;
  assign o_Score         = score_q;
  assign o_Eat           = eat_q;
  assign o_Game_Over     = (state_q == ST_OVER);
  assign o_State         = state_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
module tb_snake_body_ctrl;
  import snake_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, tick, done_in;
  logic [1:0] dir;
  logic [5:0] ix, iy;
  logic [MAX_SIZE*6-1:0] body_x, body_y;
  logic [11:0] body_size, score;
  logic        eat, game_over;
  state_e      st;

  snake_body_ctrl_if item_if ();
  assign item_if.i_Item_x    = ix;
  assign item_if.i_Item_y    = iy;
  assign item_if.i_Item_Done = done_in;

  snake_body_ctrl dut (
    .i_Clk       (clk),
    .i_Rst       (rst_n),
    .i_Start     (start),
    .i_Move_Tick (tick),
    .i_Dir       (dir),
    .item        (item_if),
    .o_Body_x    (body_x),
    .o_Body_y    (body_y),
    .o_Body_size (body_size),
    .o_Score     (score),
    .o_Eat       (eat),
    .o_Game_Over (game_over),
    .o_State     (st)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int seg_x(input int k);
    return int'(body_x[6*k +: 6]);
  endfunction
  function automatic int seg_y(input int k);
    return int'(body_y[6*k +: 6]);
  endfunction

  task automatic chk_head(input string nm, input int hx, input int hy);
    chk({nm, " head_x"}, seg_x(0), hx);
    chk({nm, " head_y"}, seg_y(0), hy);
  endtask

  // ---------------- drivers ----------------
  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic s, input logic t, input logic [1:0] d,
                     input logic dn, input logic [5:0] x, input logic [5:0] y);
    @(negedge clk);
    start = s; tick = t; dir = d; done_in = dn; ix = x; iy = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] d);
    cyc(1'b0, 1'b0, d, 1'b0, 6'd0, 6'd0);
  endtask

  task automatic ticks(input int n, input logic [1:0] d);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, d, 1'b0, 6'd0, 6'd0);
  endtask

  // Async reset: checked before any clock edge arrives.
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; tick = 0; dir = DIR_RIGHT; done_in = 0; ix = 0; iy = 0;
    #1;
    chk({nm, " rst state"}, int'(st), int'(ST_IDLE));
    chk({nm, " rst req"}, int'(item_if.o_Item_Req), 0);
    chk({nm, " rst over"}, int'(game_over), 0);
    chk({nm, " rst eat"}, int'(eat), 0);
    chk({nm, " rst size"}, int'(body_size), 3);
    chk({nm, " rst score"}, int'(score), 0);
    chk_head({nm, " rst"}, 24, 32);
    chk({nm, " rst seg1_x"}, seg_x(1), 23);
    chk({nm, " rst seg2_x"}, seg_x(2), 22);
    chk({nm, " rst seg2_y"}, seg_y(2), 32);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       s, t, dn;
    logic [1:0] d;
    logic [5:0] x, y;
    int hx, hy, tx, ty, sz, sc;
    int req, st;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic t, input logic [1:0] d,
                              input logic dn, input logic [5:0] x, input logic [5:0] y,
                              input int hx, input int hy, input int tx, input int ty,
                              input int req, input state_e e);
    vec_t v;
    v.s = s; v.t = t; v.d = d; v.dn = dn; v.x = x; v.y = y;
    v.hx = hx; v.hy = hy; v.tx = tx; v.ty = ty; v.sz = 3; v.sc = 0;
    v.req = req; v.st = int'(e);
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    start = 0; tick = 0; dir = DIR_RIGHT; done_in = 0; ix = 0; iy = 0;

    // Basic game: start, item handshake, moves, reverse drop, turn timing.
    tbl[0]  = mk(0,1,DIR_RIGHT,0,0,0,   24,32, 22,32, 0, ST_IDLE); // tick ignored in IDLE
    tbl[1]  = mk(1,0,DIR_RIGHT,0,0,0,   24,32, 22,32, 1, ST_REQ);
    tbl[2]  = mk(0,1,DIR_RIGHT,0,0,0,   24,32, 22,32, 1, ST_REQ);  // tick ignored in REQ
    tbl[3]  = mk(0,1,DIR_RIGHT,1,40,10, 24,32, 22,32, 0, ST_RUN);  // done wins over tick
    tbl[4]  = mk(0,1,DIR_RIGHT,0,0,0,   25,32, 23,32, 0, ST_RUN);
    tbl[5]  = mk(0,1,DIR_RIGHT,0,0,0,   26,32, 24,32, 0, ST_RUN);
    tbl[6]  = mk(0,1,DIR_RIGHT,0,0,0,   27,32, 25,32, 0, ST_RUN);
    tbl[7]  = mk(0,0,DIR_LEFT,0,0,0,    27,32, 25,32, 0, ST_RUN);  // reverse dropped
    tbl[8]  = mk(0,1,DIR_LEFT,0,0,0,    28,32, 26,32, 0, ST_RUN);
    tbl[9]  = mk(0,0,DIR_DOWN,0,0,0,    28,32, 26,32, 0, ST_RUN);
    tbl[10] = mk(0,1,DIR_DOWN,0,0,0,    28,33, 27,32, 0, ST_RUN);
    tbl[11] = mk(0,1,DIR_LEFT,0,0,0,    28,34, 28,32, 0, ST_RUN);  // still uses down
    tbl[12] = mk(0,1,DIR_LEFT,0,0,0,    27,34, 28,33, 0, ST_RUN);
    tbl[13] = mk(1,0,DIR_LEFT,0,0,0,    27,34, 28,33, 0, ST_RUN);  // start ignored in RUN

    repeat (2) @(posedge clk);
    do_reset("init");

    for (int i = 0; i < 14; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cyc(tbl[i].s, tbl[i].t, tbl[i].d, tbl[i].dn, tbl[i].x, tbl[i].y);
      chk_head(nm, tbl[i].hx, tbl[i].hy);
      chk({nm, " tail_x"}, seg_x(tbl[i].sz - 1), tbl[i].tx);
      chk({nm, " tail_y"}, seg_y(tbl[i].sz - 1), tbl[i].ty);
      chk({nm, " size"}, int'(body_size), tbl[i].sz);
      chk({nm, " score"}, int'(score), tbl[i].sc);
      chk({nm, " req"}, int'(item_if.o_Item_Req), tbl[i].req);
      chk({nm, " state"}, int'(st), tbl[i].st);
      chk({nm, " eat"}, int'(eat), 0);
    end

    // Mid-game reset aborts at once.
    do_reset("midgame");

    // ---- eat, then grow to 5 and run into segment 3 ----
    cyc(1, 0, DIR_RIGHT, 0, 0, 0);
    cyc(0, 0, DIR_RIGHT, 1, 25, 32);
    chk("eat pre state", int'(st), int'(ST_RUN));
    ticks(1, DIR_RIGHT);
    chk_head("eat1", 25, 32);
    chk("eat1 size", int'(body_size), 4);
    chk("eat1 pulse", int'(eat), 1);
    chk("eat1 score", int'(score), 1);
    chk("eat1 req", int'(item_if.o_Item_Req), 1);
    chk("eat1 tail_x", seg_x(3), 22);
    chk("eat1 tail_y", seg_y(3), 32);
    ticks(1, DIR_RIGHT);  // ignored in REQ
    chk("eat1 pulse end", int'(eat), 0);
    chk_head("eat1 req tick", 25, 32);
    cyc(0, 0, DIR_RIGHT, 1, 26, 32);
    ticks(1, DIR_RIGHT);
    chk("eat2 size", int'(body_size), 5);
    chk("eat2 score", int'(score), 2);
    chk("eat2 pulse", int'(eat), 1);
    cyc(0, 0, DIR_RIGHT, 1, 0, 63);
    idle(DIR_DOWN);
    ticks(1, DIR_DOWN);
    chk_head("self down", 26, 33);
    idle(DIR_LEFT);
    ticks(1, DIR_LEFT);
    chk_head("self left", 25, 33);
    chk("self seg4_x", seg_x(4), 24);
    idle(DIR_UP);
    ticks(1, DIR_UP);
    chk("self over", int'(game_over), 1);
    chk("self state", int'(st), int'(ST_OVER));
    chk_head("self frozen", 25, 33);
    chk("self size", int'(body_size), 5);
    chk("self score", int'(score), 2);
    ticks(1, DIR_UP);
    chk_head("over tick", 25, 33);
    cyc(1, 0, DIR_UP, 0, 0, 0);
    chk("restart size", int'(body_size), 3);
    chk("restart score", int'(score), 0);
    chk("restart req", int'(item_if.o_Item_Req), 1);
    chk("restart over", int'(game_over), 0);
    chk_head("restart", 24, 32);
    chk("restart seg2_x", seg_x(2), 22);

    // ---- right wall at (47,5) ----
    do_reset("wall");
    cyc(1, 0, DIR_RIGHT, 0, 0, 0);
    cyc(0, 0, DIR_RIGHT, 1, 0, 63);
    idle(DIR_UP);
    ticks(27, DIR_UP);
    chk_head("wall up leg", 24, 5);
    idle(DIR_RIGHT);
    ticks(23, DIR_RIGHT);
    chk_head("wall edge", 47, 5);
    chk("wall edge over", int'(game_over), 0);
    ticks(1, DIR_RIGHT);
    chk("wall right over", int'(game_over), 1);
    chk_head("wall right frozen", 47, 5);
    chk("wall right seg1_x", seg_x(1), 46);
    chk("wall right size", int'(body_size), 3);

    // ---- top wall at (0,0) after restart from OVER ----
    cyc(1, 0, DIR_RIGHT, 0, 0, 0);
    chk_head("wall2 restart", 24, 32);
    cyc(0, 0, DIR_RIGHT, 1, 47, 63);
    idle(DIR_UP);
    ticks(32, DIR_UP);
    chk_head("wall2 top row", 24, 0);
    idle(DIR_LEFT);
    ticks(24, DIR_LEFT);
    chk_head("wall2 corner", 0, 0);
    chk("wall2 corner over", int'(game_over), 0);
    idle(DIR_UP);
    ticks(1, DIR_UP);
    chk("wall2 up over", int'(game_over), 1);
    chk_head("wall2 frozen", 0, 0);
    chk("wall2 score", int'(score), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
